uart_fifo_ip: RTL and testbench

Memory-mapped, parametrised UART peripheral for the RISC-V SoC data bus. It is the successor to the single-register UART IP and adds TX and RX FIFOs of parametrised depth, a runtime-programmable baud divisor, sticky error flags and a level interrupt. Software moves bytes through one DATA register instead of hand-shaking start, finish and clear bits. The block sits on the peripheral decode of the data memory map, and `tx`/`rx` connect to the board pins.

---
 rtl/uart_fifo_ip_if.sv | 14 +
 rtl/uart_fifo_ip.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_ip.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_ip_if.sv
// Register-bus bundle for uart_fifo_ip: byte address, write/read strobes and
// combinational read data.
interface uart_fifo_ip_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wd;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] rd;

    modport master (output address, wd, we, re, input rd);
    modport slave  (input address, wd, we, re, output rd);
endinterface

// File: rtl/uart_fifo_ip.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, programmable baud divisor,
// sticky error flags and a registered level interrupt.
module uart_fifo_ip #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 433
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_fifo_ip_if.slave bus,
    output logic          irq,
    input  logic          rx,
    output logic          tx
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic [2:0]  idx;
    logic        wr_data, wr_ctrl, wr_baud, sticky_clr, flush;
    logic        tx_en, rx_en, irq_rx_en, irq_txe_en;
    logic [15:0] div_eff;
    logic        unused_bits;

    logic [3:0]  ctrl_q, ctrl_d;
    logic [15:0] baud_q, baud_d;
    logic        tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, frame_err_q, frame_err_d;
    logic        irq_q, irq_d;

    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] txf_wp_q, txf_wp_d, txf_rp_q, txf_rp_d;
    logic [CNT_W-1:0] txf_cnt_q, txf_cnt_d;
    logic             tx_full, tx_empty, tx_push, tx_pop, tx_ovf_evt;

    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rxf_wp_q, rxf_wp_d, rxf_rp_q, rxf_rp_d;
    logic [CNT_W-1:0] rxf_cnt_q, rxf_cnt_d;
    logic             rx_full, rx_empty, rx_acc, rx_pop, rx_ovr_evt;

    state_e      tx_state_q, tx_state_d;
    logic [15:0] tx_tmr_q, tx_tmr_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d, tx_busy;

    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    state_e      rx_state_q, rx_state_d;
    logic [15:0] rx_tmr_q, rx_tmr_d, rx_div_q, rx_div_d, rx_mid;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic        rx_push_q, rx_push_d, frame_evt;

    logic [DATA_WIDTH-1:0] status;

    always_comb begin
        idx         = bus.address[4:2];
        wr_data     = bus.we && (idx == 3'd0);
        wr_ctrl     = bus.we && (idx == 3'd2);
        wr_baud     = bus.we && (idx == 3'd3);
        sticky_clr  = wr_ctrl && bus.wd[8];
        flush       = wr_ctrl && bus.wd[9];
        tx_en       = ctrl_q[0];
        rx_en       = ctrl_q[1];
        irq_rx_en   = ctrl_q[2];
        irq_txe_en  = ctrl_q[3];
        div_eff     = (baud_q < 16'd3) ? 16'd3 : baud_q;
        tx_full     = (txf_cnt_q == DEPTH_C);
        tx_empty    = (txf_cnt_q == '0);
        rx_full     = (rxf_cnt_q == DEPTH_C);
        rx_empty    = (rxf_cnt_q == '0);
        tx_busy     = (tx_state_q != S_IDLE);
        rx_mid      = {1'b0, rx_div_q[15:1]};
        unused_bits = ^{bus.address[DATA_WIDTH-1:5], bus.address[1:0], bus.wd[DATA_WIDTH-1:16]};
    end

    // A finishing stop bit may start the next queued frame directly, so the
    // pop/start path is shared between IDLE and the end of STOP.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tmr_d   = tx_tmr_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        if ((tx_state_q == S_IDLE) ||
            ((tx_state_q == S_STOP) && (tx_tmr_q == tx_div_q))) begin
            tx_state_d = S_IDLE;
            tx_d       = 1'b1;
            if (tx_en && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_state_d = S_START;
                tx_tmr_d   = '0;
                tx_div_d   = div_eff;
                tx_shift_d = tx_mem_q[txf_rp_q];
                tx_d       = 1'b0;
            end
        end else if (tx_tmr_q != tx_div_q) begin
            tx_tmr_d = tx_tmr_q + 16'd1;
        end else begin
            tx_tmr_d = '0;
            case (tx_state_q)
                S_START: begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
                S_DATA: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end
                default: tx_state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tmr_d   = rx_tmr_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_push_d  = 1'b0;
        frame_evt  = 1'b0;
        if (!rx_en) begin
            rx_state_d = S_IDLE;
        end else begin
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        rx_state_d = S_START;
                        rx_tmr_d   = '0;
                        rx_div_d   = div_eff;
                    end
                end
                S_START: begin
                    if (rx_tmr_q == rx_mid) begin
                        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                        rx_tmr_d   = '0;
                        rx_bit_d   = '0;
                    end else begin
                        rx_tmr_d = rx_tmr_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tmr_q == rx_div_q) begin
                        rx_tmr_d   = '0;
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                    end else begin
                        rx_tmr_d = rx_tmr_q + 16'd1;
                    end
                end
                default: begin
                    if (rx_tmr_q == rx_div_q) begin
                        rx_state_d = S_IDLE;
                        rx_tmr_d   = '0;
                        if (rx_s2_q) begin
                            rx_push_d = 1'b1;
                            rx_byte_d = rx_shift_q;
                        end else begin
                            frame_evt = 1'b1;
                        end
                    end else begin
                        rx_tmr_d = rx_tmr_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // A pop in the same cycle frees the slot a full FIFO needs for its push.
    always_comb begin
        tx_push    = wr_data && (!tx_full || tx_pop);
        tx_ovf_evt = wr_data && tx_full && !tx_pop;
        rx_pop     = bus.re && (idx == 3'd0) && !rx_empty;
        rx_acc     = rx_push_q && !flush && (!rx_full || rx_pop);
        rx_ovr_evt = rx_push_q && rx_full && !rx_pop;

        txf_wp_d  = txf_wp_q;
        txf_rp_d  = txf_rp_q;
        txf_cnt_d = txf_cnt_q;
        if (flush) begin
            txf_wp_d  = '0;
            txf_rp_d  = '0;
            txf_cnt_d = '0;
        end else begin
            if (tx_push) txf_wp_d = txf_wp_q + PTR_W'(1);
            if (tx_pop)  txf_rp_d = txf_rp_q + PTR_W'(1);
            if (tx_push && !tx_pop)      txf_cnt_d = txf_cnt_q + CNT_W'(1);
            else if (!tx_push && tx_pop) txf_cnt_d = txf_cnt_q - CNT_W'(1);
        end

        rxf_wp_d  = rxf_wp_q;
        rxf_rp_d  = rxf_rp_q;
        rxf_cnt_d = rxf_cnt_q;
        if (flush) begin
            rxf_wp_d  = '0;
            rxf_rp_d  = '0;
            rxf_cnt_d = '0;
        end else begin
            if (rx_acc) rxf_wp_d = rxf_wp_q + PTR_W'(1);
            if (rx_pop) rxf_rp_d = rxf_rp_q + PTR_W'(1);
            if (rx_acc && !rx_pop)      rxf_cnt_d = rxf_cnt_q + CNT_W'(1);
            else if (!rx_acc && rx_pop) rxf_cnt_d = rxf_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        ctrl_d      = wr_ctrl ? bus.wd[3:0] : ctrl_q;
        baud_d      = wr_baud ? bus.wd[15:0] : baud_q;
        tx_ovf_d    = (tx_ovf_q && !sticky_clr) || tx_ovf_evt;
        rx_ovr_d    = (rx_ovr_q && !sticky_clr) || rx_ovr_evt;
        frame_err_d = (frame_err_q && !sticky_clr) || frame_evt;
        irq_d       = (irq_rx_en && !rx_empty) ||
                      (irq_txe_en && tx_empty && !tx_busy) ||
                      (irq_rx_en && (rx_ovr_q || frame_err_q));

        status              = '0;
        status[0]           = tx_full;
        status[1]           = tx_empty;
        status[2]           = rx_full;
        status[3]           = rx_empty;
        status[4]           = rx_ovr_q;
        status[5]           = frame_err_q;
        status[6]           = tx_ovf_q;
        status[7]           = tx_busy;
        status[8 +: CNT_W]  = rxf_cnt_q;

        bus.rd = '0;
        case (idx)
            3'd0:    if (!rx_empty) bus.rd[7:0] = rx_mem_q[rxf_rp_q];
            3'd1:    bus.rd = status;
            3'd2:    bus.rd[3:0] = ctrl_q;
            3'd3:    bus.rd[15:0] = baud_q;
            default: bus.rd = '0;
        endcase

        tx  = tx_q;
        irq = irq_q;
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[txf_wp_q] <= bus.wd[7:0];
        if (rx_acc)  rx_mem_q[rxf_wp_q] <= rx_byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= 4'h3;
            baud_q      <= 16'(DEFAULT_DIV);
            tx_ovf_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            irq_q       <= 1'b0;
            txf_wp_q    <= '0;
            txf_rp_q    <= '0;
            txf_cnt_q   <= '0;
            rxf_wp_q    <= '0;
            rxf_rp_q    <= '0;
            rxf_cnt_q   <= '0;
            tx_state_q  <= S_IDLE;
            tx_tmr_q    <= '0;
            tx_div_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= S_IDLE;
            rx_tmr_q    <= '0;
            rx_div_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_push_q   <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            baud_q      <= baud_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            irq_q       <= irq_d;
            txf_wp_q    <= txf_wp_d;
            txf_rp_q    <= txf_rp_d;
            txf_cnt_q   <= txf_cnt_d;
            rxf_wp_q    <= rxf_wp_d;
            rxf_rp_q    <= rxf_rp_d;
            rxf_cnt_q   <= rxf_cnt_d;
            tx_state_q  <= tx_state_d;
            tx_tmr_q    <= tx_tmr_d;
            tx_div_q    <= tx_div_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_prev_q   <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_tmr_q    <= rx_tmr_d;
            rx_div_q    <= rx_div_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_push_q   <= rx_push_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo_ip.sv
// Scoreboard bench for uart_fifo_ip: stimulus queues expected register reads,
// pin levels and TX frames; independent monitors pop and compare.
module tb_uart_fifo_ip;
    localparam int P = 4;  // clocks per bit with BAUD=3

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq, tx, rx_line;
    logic rx_drv = 1'b1;
    logic loop_en = 1'b0;

    always #5 clk = ~clk;

    uart_fifo_ip_if #(.DATA_WIDTH(32)) bus ();

    assign rx_line = loop_en ? tx : rx_drv;

    uart_fifo_ip #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .DEFAULT_DIV(433)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .irq  (irq),
        .rx   (rx_line),
        .tx   (tx)
    );

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    logic [31:0] exp_val[$];
    string       exp_name[$];
    logic [7:0]  exp_tx_byte[$];
    int          exp_tx_gap[$];

    logic        mon_en = 1'b0;
    int          mon_sel = 0;
    logic [31:0] act, ev;
    string       nm;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            case (mon_sel)
                0:       act = bus.rd;
                1:       act = {31'b0, irq};
                default: act = {31'b0, tx};
            endcase
            n_checks++;
            if (exp_val.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_sample: got %h, required a queued expectation", act);
            end else begin
                ev = exp_val.pop_front();
                nm = exp_name.pop_front();
                if (act !== ev) begin
                    n_err++;
                    $display("FAIL %s: got %h, required %h", nm, act, ev);
                end
            end
        end
    end

    int         tx_t = 0;
    bit         tx_act = 1'b0;
    logic [9:0] tx_fr;
    int         last_start = -1;
    int         tx_gap = 0;
    logic [7:0] eb;
    int         eg;

    always @(negedge clk) begin
        if (!tx_act) begin
            if (tx === 1'b0) begin
                tx_act     = 1'b1;
                tx_t       = 0;
                tx_gap     = (last_start < 0) ? 0 : cyc - last_start;
                last_start = cyc;
            end
        end else begin
            tx_t++;
        end
        if (tx_act && ((tx_t % P) == P / 2)) begin
            tx_fr[tx_t / P] = tx;
            if (tx_t / P == 9) begin
                tx_act = 1'b0;
                n_checks++;
                if (exp_tx_byte.size() == 0) begin
                    n_err++;
                    $display("FAIL tx_frame: got frame %h, required no frame", tx_fr);
                end else begin
                    eb = exp_tx_byte.pop_front();
                    eg = exp_tx_gap.pop_front();
                    if (tx_fr !== {1'b1, eb, 1'b0}) begin
                        n_err++;
                        $display("FAIL tx_frame: got %h, required %h", tx_fr, {1'b1, eb, 1'b0});
                    end
                    if (eg != 0) begin
                        n_checks++;
                        if (tx_gap != eg) begin
                            n_err++;
                            $display("FAIL tx_gap: got %0d, required %0d", tx_gap, eg);
                        end
                    end
                end
            end
        end
    end

    task automatic wr(input logic [2:0] i, input logic [31:0] d);
        bus.address = {27'b0, i, 2'b00};
        bus.wd      = d;
        bus.we      = 1'b1;
        @(posedge clk); #1;
        bus.we      = 1'b0;
    endtask

    task automatic expect_at(input int sel, input logic [2:0] i, input logic [31:0] e,
                             input string name, input logic pop);
        exp_val.push_back(e);
        exp_name.push_back(name);
        bus.address = {27'b0, i, 2'b00};
        bus.re      = pop;
        mon_sel     = sel;
        mon_en      = 1'b1;
        @(posedge clk); #1;
        mon_en      = 1'b0;
        bus.re      = 1'b0;
    endtask

    task automatic rd_chk(input logic [2:0] i, input logic [31:0] e, input string name);
        expect_at(0, i, e, name, 1'b0);
    endtask

    task automatic rd_pop(input logic [31:0] e, input string name);
        expect_at(0, 3'd0, e, name, 1'b1);
    endtask

    task automatic pin_chk(input int sel, input logic [31:0] e, input string name);
        expect_at(sel, 3'd0, e, name, 1'b0);
    endtask

    task automatic tx_expect(input logic [7:0] b, input int gap);
        exp_tx_byte.push_back(b);
        exp_tx_gap.push_back(gap);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = fr[k];
            repeat (P) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] rx_tbl [9];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        rx_tbl = '{8'h01, 8'h80, 8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h33, 8'hC3, 8'h99};
        bus.address = '0;
        bus.wd      = '0;
        bus.we      = 1'b0;
        bus.re      = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        rd_chk(3'd1, 32'h0A, "reset_status");
        rd_chk(3'd2, 32'h3, "reset_ctrl");
        rd_chk(3'd3, 32'd433, "reset_baud");
        rd_chk(3'd0, 32'h0, "reset_data_empty");
        pin_chk(2, 32'h1, "reset_tx");
        pin_chk(1, 32'h0, "reset_irq");

        // Back-to-back frames at BAUD=3
        wr(3'd3, 32'd3);
        tx_expect(8'h55, 0);
        tx_expect(8'hA3, 10 * P);
        wr(3'd0, 32'h55);
        wr(3'd0, 32'hA3);
        rd_chk(3'd1, 32'h88, "tx_busy_status");
        idle(90);
        rd_chk(3'd1, 32'h0A, "tx_done_status");

        // Loopback with RX interrupt
        loop_en = 1'b1;
        wr(3'd2, 32'h7);
        tx_expect(8'h3C, 0);
        wr(3'd0, 32'h3C);
        for (int k = 0; k < 200 && irq !== 1'b1; k++) idle(1);
        pin_chk(1, 32'h1, "loop_irq_high");
        idle(12);
        rd_pop(32'h3C, "loop_data");
        rd_chk(3'd1, 32'h0A, "loop_status_after_pop");
        pin_chk(1, 32'h0, "loop_irq_low");
        loop_en = 1'b0;
        wr(3'd2, 32'h3);

        // RX overrun: nine frames into an eight-entry FIFO
        for (int i = 0; i < 9; i++) send_rx(rx_tbl[i], 1'b1);
        idle(8);
        rd_chk(3'd1, 32'h816, "ovr_status");
        for (int i = 0; i < 8; i++) rd_pop({24'b0, rx_tbl[i]}, "ovr_data");
        wr(3'd2, 32'h103);
        rd_chk(3'd1, 32'h0A, "ovr_cleared_status");
        rd_chk(3'd2, 32'h3, "ctrl_selfclear");

        // Framing error followed by a one-clock glitch
        send_rx(8'h42, 1'b0);
        idle(8);
        rx_drv = 1'b0;
        idle(1);
        rx_drv = 1'b1;
        idle(20);
        rd_chk(3'd1, 32'h2A, "ferr_status");
        wr(3'd2, 32'h103);
        rd_chk(3'd1, 32'h0A, "ferr_cleared_status");

        // TX overflow with tx_en=0, then flush and re-enable
        wr(3'd2, 32'h2);
        for (int i = 0; i < 9; i++) wr(3'd0, 32'h60 + i);
        rd_chk(3'd1, 32'h49, "ovf_status");
        wr(3'd2, 32'h202);
        rd_chk(3'd1, 32'h4A, "flush_status");
        wr(3'd2, 32'h3);
        for (int k = 0; k < 4; k++) begin
            idle(10);
            pin_chk(2, 32'h1, "flush_tx_idle");
        end
        rd_chk(3'd1, 32'h4A, "flush_after_enable");

        // Divisor below the minimum behaves as 3
        wr(3'd2, 32'h103);
        wr(3'd3, 32'd0);
        tx_expect(8'h81, 0);
        wr(3'd0, 32'h81);
        idle(60);
        rd_chk(3'd1, 32'h0A, "clamp_done_status");

        idle(5);
        n_checks++;
        if (exp_tx_byte.size() != 0) begin
            n_err++;
            $display("FAIL tx_pending: got %0d unsent frames, required 0", exp_tx_byte.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
